// File: rtl/mcoi_rs485_rx_pkg.sv
// Shared types and helpers for the RS485 UART receive path.
package McoiUartPkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       frame_err;
    logic       parity_err;
  } rx_word_t;

  // Clocks per oversample tick, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_hz / (baud * os);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mcoi_baud_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks, restartable.
module mcoi_baud_tick #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = 1'b0;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DIV - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/mcoi_rs485_rx.sv
// RS485 service-link UART receiver: 8N1/8E1/8O1 deserialiser with a
// one-entry valid/ready output buffer, frame/parity error and overrun flags.
module mcoi_rs485_rx
  import McoiUartPkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned PARITY_EN   = 0,
  parameter int unsigned PARITY_ODD  = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rs485_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o,
  input  logic       clear_i,
  output logic       busy_o
);

  localparam int unsigned DIV    = baud_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned SAMP_W = $clog2(OVERSAMPLE);
  localparam logic [SAMP_W-1:0] S_A    = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] S_B    = SAMP_W'(OVERSAMPLE / 2);
  localparam logic [SAMP_W-1:0] S_C    = SAMP_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SAMP_W-1:0] S_LAST = SAMP_W'(OVERSAMPLE - 1);

  logic [1:0]        sync_q;
  logic              prev_q;
  logic [2:0]        arm_q;
  logic              rx_s, fall_c, tick_c, restart_c;
  logic              bit_c, decide_c, end_c, load_c;
  rx_state_t         state_q, state_d;
  logic [SAMP_W-1:0] samp_q, samp_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [1:0]        maj_q, maj_d;
  rx_word_t          word_c, word_q;
  logic              valid_q, ovr_q, busy_q;

  // Synchroniser plus edge history; arm_q masks the reset-value "high" so a
  // line already low at reset release is not mistaken for a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      arm_q  <= 3'b000;
    end else begin
      sync_q <= {sync_q[0], rs485_i};
      prev_q <= sync_q[1];
      arm_q  <= {arm_q[1:0], 1'b1};
    end
  end

  assign rx_s   = sync_q[1];
  assign fall_c = arm_q[2] & prev_q & ~rx_s;

  mcoi_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk       (clk),
    .rstn      (rstn),
    .restart_i (restart_c),
    .tick_o    (tick_c)
  );

  assign decide_c = tick_c && (samp_q == S_C);
  assign end_c    = tick_c && (samp_q == S_LAST);
  assign bit_c    = maj3(maj_q[1], maj_q[0], rx_s);

  always_comb begin
    word_c.data       = shift_q;
    word_c.frame_err  = ~bit_c;
    word_c.parity_err = (PARITY_EN != 0) ? ((^shift_q) ^ par_q ^ (PARITY_ODD != 0)) : 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    maj_d     = maj_q;
    restart_c = 1'b0;
    load_c    = 1'b0;
    if (tick_c) begin
      samp_d = end_c ? '0 : samp_q + SAMP_W'(1);
      if (samp_q == S_A) maj_d[1] = rx_s;
      if (samp_q == S_B) maj_d[0] = rx_s;
    end
    unique case (state_q)
      IDLE: begin
        samp_d = '0;
        bit_d  = '0;
        if (fall_c) begin
          state_d   = START;
          restart_c = 1'b1;
        end
      end
      START: begin
        if (decide_c && bit_c) state_d = IDLE;
        else if (end_c)        state_d = DATA;
      end
      DATA: begin
        if (decide_c) shift_d = {bit_c, shift_q[7:1]};
        if (end_c) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (decide_c) par_d = bit_c;
        if (end_c)    state_d = STOP;
      end
      STOP: begin
        // Leave at the decision point so a back-to-back start edge is caught.
        if (decide_c) begin
          load_c  = 1'b1;
          state_d = bit_c ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      maj_q   <= '0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      maj_q   <= maj_d;
    end
  end

  // One-entry output buffer; a byte arriving while the consumer stalls is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      if (load_c && valid_q && !ready_i) ovr_q <= 1'b1;
      else if (clear_i)                  ovr_q <= 1'b0;
      if (load_c && !(valid_q && !ready_i)) begin
        word_q  <= word_c;
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o       = word_q.data;
  assign frame_err_o  = word_q.frame_err;
  assign parity_err_o = word_q.parity_err;
  assign valid_o      = valid_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_mcoi_rs485_rx.sv
// Self-checking bench: an 8N1 and an 8E1 receiver driven by a bit-level line
// model, with an expected-byte scoreboard checked on every handshake.
module tb_mcoi_rs485_rx;
  import McoiUartPkg::rx_word_t;

  localparam int BIT_CLK = 160;

  logic clk = 1'b0;
  logic rstn;
  logic line_n, line_p, ready_n, ready_p, clear_n, clear_p;
  logic [7:0] data_n, data_p;
  logic valid_n, valid_p, fe_n, fe_p, pe_n, pe_p, ovr_n, ovr_p, busy_n, busy_p;

  always #5 clk = ~clk;

  mcoi_rs485_rx #(
    .CLK_FREQ_HZ(100000000), .BAUD(625000), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)
  ) u_dut_n (
    .clk(clk), .rstn(rstn), .rs485_i(line_n), .data_o(data_n), .valid_o(valid_n),
    .ready_i(ready_n), .frame_err_o(fe_n), .parity_err_o(pe_n), .overrun_o(ovr_n),
    .clear_i(clear_n), .busy_o(busy_n)
  );

  mcoi_rs485_rx #(
    .CLK_FREQ_HZ(100000000), .BAUD(625000), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)
  ) u_dut_p (
    .clk(clk), .rstn(rstn), .rs485_i(line_p), .data_o(data_p), .valid_o(valid_p),
    .ready_i(ready_p), .frame_err_o(fe_p), .parity_err_o(pe_p), .overrun_o(ovr_p),
    .clear_i(clear_p), .busy_o(busy_p)
  );

  logic [1:0] valid_a, ready_a, ovr_a;
  rx_word_t   got_a [2];
  assign valid_a  = {valid_p, valid_n};
  assign ready_a  = {ready_p, ready_n};
  assign ovr_a    = {ovr_p, ovr_n};
  assign got_a[0] = {data_n, fe_n, pe_n};
  assign got_a[1] = {data_p, fe_p, pe_p};

  rx_word_t exp_q [2][$];
  int n_chk = 0;
  int n_fail = 0;
  bit chk_ovr0 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Expected word from the frame as sent: stop low is a frame error; the
  // parity instance uses even parity over data plus parity bit.
  function automatic rx_word_t model_word(input bit use_p, input logic [7:0] d,
                                          input bit pbit, input bit stopb);
    rx_word_t w;
    w.data       = d;
    w.frame_err  = !stopb;
    w.parity_err = use_p ? ((($countones(d) + int'(pbit)) % 2) != 0) : 1'b0;
    return w;
  endfunction

  task automatic drive_bit(input bit use_p, input logic b, input int ncyc);
    if (use_p) line_p = b;
    else       line_n = b;
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit use_p, input logic [7:0] d, input bit pbit,
                            input bit stopb, input bit push);
    if (push) exp_q[int'(use_p)].push_back(model_word(use_p, d, pbit, stopb));
    drive_bit(use_p, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive_bit(use_p, d[i], BIT_CLK);
    if (use_p) drive_bit(use_p, pbit, BIT_CLK);
    drive_bit(use_p, stopb, BIT_CLK);
  endtask

  task automatic wait_valid(input bit use_p, output rx_word_t w, output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    w   = '0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (valid_a[int'(use_p)]) begin
        ok = 1'b1;
        w  = got_a[int'(use_p)];
      end
    end
  endtask

  // Scoreboard and hold-stability checks on every cycle out of reset.
  logic [1:0] pv = '0, pr = '0;
  rx_word_t   pw [2];
  rx_word_t   e;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        pv[k] = 1'b0;
      end else begin
        if (pv[k] && !pr[k])
          check($sformatf("buffer_hold_dut%0d", k), 32'({valid_a[k], got_a[k]}), 32'({1'b1, pw[k]}));
        if (valid_a[k] && ready_a[k]) begin
          if (exp_q[k].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_byte_dut%0d: got %0h expected none", k, got_a[k]);
          end else begin
            e = exp_q[k].pop_front();
            check($sformatf("rx_word_dut%0d", k), 32'(got_a[k]), 32'(e));
          end
        end
        if (chk_ovr0) check($sformatf("no_overrun_dut%0d", k), 32'(ovr_a[k]), 32'd0);
        pv[k] = valid_a[k];
        pr[k] = ready_a[k];
        pw[k] = got_a[k];
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  rx_word_t w;
  int  lat, gap;
  bit  ok, v_after, done, up, pb, sb;
  logic [7:0] d;

  initial begin
    rstn = 1'b0; line_n = 1'b1; line_p = 1'b1;
    ready_n = 1'b1; ready_p = 1'b1; clear_n = 1'b0; clear_p = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_outputs_n", 32'({data_n, valid_n, fe_n, pe_n, ovr_n, busy_n}), 32'd0);
    check("reset_outputs_p", 32'({data_p, valid_p, fe_p, pe_p, ovr_p, busy_p}), 32'd0);
    rstn = 1'b1;
    drive_bit(0, 1'b1, 20);
    chk_ovr0 = 1'b1;

    // 1: single 8N1 byte, latency and one-cycle valid pulse
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
      begin
        wait_valid(0, w, lat, ok);
        @(negedge clk);
        v_after = valid_n;
      end
    join
    check("t1_valid_seen", 32'(ok), 32'd1);
    check("t1_data", 32'(w.data), 32'hA5);
    check("t1_frame_err", 32'(w.frame_err), 32'd0);
    check("t1_parity_err", 32'(w.parity_err), 32'd0);
    check_range("t1_latency", lat, 1530, 1560);
    check("t1_pulse_width", 32'(v_after), 32'd0);

    // 2: back-to-back frames, no idle gap
    send_frame(0, 8'h00, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
    drive_bit(0, 1'b1, BIT_CLK);
    check("t2_overrun", 32'(ovr_n), 32'd0);

    // 3: short low glitch rejected
    drive_bit(0, 1'b0, 40);
    check("t3_busy_during_glitch", 32'(busy_n), 32'd1);
    drive_bit(0, 1'b1, 120);
    check("t3_busy_after_glitch", 32'(busy_n), 32'd0);
    drive_bit(0, 1'b1, BIT_CLK);

    // 4: break frame, line held low, then recovery
    fork
      send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
      wait_valid(0, w, lat, ok);
    join
    check("t4_valid_seen", 32'(ok), 32'd1);
    check("t4_data", 32'(w.data), 32'h55);
    check("t4_frame_err", 32'(w.frame_err), 32'd1);
    drive_bit(0, 1'b0, 2 * BIT_CLK);
    check("t4_busy_while_low", 32'(busy_n), 32'd1);
    drive_bit(0, 1'b1, 2 * BIT_CLK);
    check("t4_idle_after_high", 32'(busy_n), 32'd0);
    send_frame(0, 8'h12, 1'b0, 1'b1, 1'b1);
    drive_bit(0, 1'b1, BIT_CLK);

    // 5: even parity, wrong then right parity bit
    fork
      send_frame(1, 8'h07, 1'b0, 1'b1, 1'b1);
      wait_valid(1, w, lat, ok);
    join
    check("t5_bad_parity_flag", 32'({ok, w.data, w.parity_err}), 32'({1'b1, 8'h07, 1'b1}));
    drive_bit(1, 1'b1, BIT_CLK);
    fork
      send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
      wait_valid(1, w, lat, ok);
    join
    check("t5_good_parity_flag", 32'({ok, w.data, w.parity_err}), 32'({1'b1, 8'h07, 1'b0}));
    drive_bit(1, 1'b1, BIT_CLK);

    // 6: overrun under back-pressure, clear, then reset mid-frame
    chk_ovr0 = 1'b0;
    ready_n  = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b0);
    check("t6_held_data", 32'({valid_n, data_n}), 32'({1'b1, 8'h11}));
    check("t6_overrun_set", 32'(ovr_n), 32'd1);
    ready_n = 1'b1;
    clear_n = 1'b1;
    @(posedge clk);
    #1;
    clear_n = 1'b0;
    check("t6_valid_after_xfer", 32'(valid_n), 32'd0);
    check("t6_overrun_cleared", 32'(ovr_n), 32'd0);
    chk_ovr0 = 1'b1;
    drive_bit(0, 1'b0, BIT_CLK);
    drive_bit(0, 1'b1, BIT_CLK);
    drive_bit(0, 1'b0, 80);
    check("t6_busy_mid_frame", 32'(busy_n), 32'd1);
    rstn   = 1'b0;
    line_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t6_reset_outputs", 32'({data_n, valid_n, fe_n, pe_n, ovr_n, busy_n}), 32'd0);
    rstn = 1'b1;
    drive_bit(0, 1'b1, 2 * BIT_CLK);
    fork
      send_frame(0, 8'h33, 1'b0, 1'b1, 1'b1);
      wait_valid(0, w, lat, ok);
    join
    check("t6_after_reset", 32'({ok, w.data, w.frame_err}), 32'({1'b1, 8'h33, 1'b0}));
    drive_bit(0, 1'b1, BIT_CLK);

    // Random bytes, parity bits, stop errors, gaps and consumer stalls
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          up  = 1'($urandom_range(0, 1));
          d   = 8'($urandom);
          pb  = 1'($urandom_range(0, 1));
          sb  = ($urandom_range(0, 4) != 0);
          gap = int'($urandom_range(0, 2));
          send_frame(up, d, pb, sb, 1'b1);
          if (!sb)          drive_bit(up, 1'b1, BIT_CLK);
          else if (gap > 0) drive_bit(up, 1'b1, gap * BIT_CLK);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          ready_n = 1'($urandom_range(0, 1));
          ready_p = 1'($urandom_range(0, 1));
        end
        ready_n = 1'b1;
        ready_p = 1'b1;
      end
    join
    repeat (2 * BIT_CLK) @(posedge clk);
    #1;
    check("drain_dut0", 32'(exp_q[0].size()), 32'd0);
    check("drain_dut1", 32'(exp_q[1].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
